// File: rtl/noise_sample_conditioner.sv
// Noise sample conditioner: removes the DC mean from the sum-of-uniforms noise
// lanes, applies a Q4.4 gain, then rounds and saturates each lane to signed
// OUT_BITS. Frames are emitted in software-triggered bursts through a
// three-stage pipeline, with busy/done status and a saturation counter.
module noise_sample_conditioner #(
    parameter int unsigned NSAMP     = 8,
    parameter int unsigned IN_BITS   = 16,
    parameter int unsigned OUT_BITS  = 12,
    parameter int unsigned MEAN      = 2040,
    parameter int unsigned GAIN_FRAC = 4
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic [NSAMP*IN_BITS-1:0]  noise_i,
    input  logic [7:0]                gain_i,
    input  logic [15:0]               burst_len_i,
    input  logic                      start_i,
    output logic [NSAMP*OUT_BITS-1:0] noise_o,
    output logic                      valid_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [15:0]               sat_count_o
);

    localparam int unsigned DW = IN_BITS + 1;  // centred sample width
    localparam int unsigned PW = DW + 9;       // product width (gain is 8-bit unsigned)
    localparam int unsigned RW = PW + 1;       // headroom for the rounding add
    localparam int unsigned CW = $clog2(NSAMP + 1);

    localparam logic [DW-1:0]        MEAN_V  = DW'(MEAN);
    localparam logic signed [RW-1:0] ROUND_V = RW'(1 << (GAIN_FRAC - 1));
    localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (OUT_BITS - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_t;

    state_t                    r_state, w_state_d;
    logic                      r_done, w_done_d;
    logic                      w_accept, w_issue;
    logic [7:0]                r_gain;
    logic [15:0]               r_len;
    logic [15:0]               r_cnt;
    logic                      r_t1, r_t2, r_t3;
    logic [15:0]               r_sat, w_sat_d;
    logic [16:0]               w_sat_sum;
    logic [CW-1:0]             w_nsat;
    logic signed [DW-1:0]      r_s1_d [NSAMP];
    logic signed [PW-1:0]      r_s2_p [NSAMP];
    logic [NSAMP*OUT_BITS-1:0] r_out, w_out;

    // Burst sequencing: accept a start in idle, issue one frame per cycle, drain.
    always_comb begin
        w_state_d = r_state;
        w_done_d  = 1'b0;
        w_accept  = 1'b0;
        w_issue   = 1'b0;
        unique case (r_state)
            StIdle: begin
                // The idle cycle that shows done_o still counts as busy.
                if (start_i && !r_done) begin
                    w_accept = 1'b1;
                    if (burst_len_i != 16'd0) begin
                        w_state_d = StRun;
                    end else begin
                        w_done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                w_issue = 1'b1;
                if (r_cnt == r_len - 16'd1) begin
                    w_state_d = StFlush;
                end
            end
            StFlush: begin
                // Leave once only the output stage can still hold a frame, so
                // done_o lands right after the last valid_o.
                if (!r_t1 && !r_t2) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Stage 3: round half toward +inf, saturate, and count clamped lanes.
    always_comb begin
        logic signed [RW-1:0] v;
        w_out  = '0;
        w_nsat = '0;
        v      = '0;
        for (int k = 0; k < NSAMP; k++) begin
            v = (RW'(r_s2_p[k]) + ROUND_V) >>> GAIN_FRAC;
            if (v > SAT_MAX) begin
                w_out[k*OUT_BITS +: OUT_BITS] = SAT_MAX[OUT_BITS-1:0];
                w_nsat = w_nsat + CW'(1);
            end else if (v < SAT_MIN) begin
                w_out[k*OUT_BITS +: OUT_BITS] = SAT_MIN[OUT_BITS-1:0];
                w_nsat = w_nsat + CW'(1);
            end else begin
                w_out[k*OUT_BITS +: OUT_BITS] = v[OUT_BITS-1:0];
            end
        end
        w_sat_sum = {1'b0, r_sat} + 17'(w_nsat);
        w_sat_d   = w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
    end

    // Control state, pipeline valid tags, output register and saturation count.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
            r_gain  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_t1    <= 1'b0;
            r_t2    <= 1'b0;
            r_t3    <= 1'b0;
            r_sat   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_d;
            r_done  <= w_done_d;
            r_t1    <= w_issue;
            r_t2    <= r_t1;
            r_t3    <= r_t2;
            if (w_accept) begin
                r_gain <= gain_i;
                r_len  <= burst_len_i;
                r_cnt  <= '0;
                r_sat  <= '0;
            end else begin
                if (w_issue) begin
                    r_cnt <= r_cnt + 16'd1;
                end
                if (r_t2) begin
                    r_sat <= w_sat_d;
                end
            end
            if (r_t2) begin
                r_out <= w_out;
            end
        end
    end

    // Stages 1-2: centre each lane, then apply the latched gain; tags mark validity.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NSAMP; k++) begin
            r_s1_d[k] <= $signed({1'b0, noise_i[k*IN_BITS +: IN_BITS]} - MEAN_V);
            r_s2_p[k] <= PW'(r_s1_d[k]) * PW'($signed({1'b0, r_gain}));
        end
    end

    assign noise_o     = r_out;
    assign valid_o     = r_t3;
    assign done_o      = r_done;
    assign busy_o      = (r_state != StIdle) || r_done;
    assign sat_count_o = r_sat;

endmodule
